// File: rtl/pc_gen_pkg.sv
// Shared types for the program-counter generator: FSM state encoding,
// next-PC select and the per-cycle control bundle.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } pc_state_e;

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_STEP,
    SEL_REDIR,
    SEL_TRAP,
    SEL_EPC
  } pc_sel_e;

  typedef struct packed {
    pc_sel_e sel;
    logic    valid;
    logic    save_epc;
    logic    take_bad;
  } pc_ctrl_t;

endpackage

// File: rtl/pc_target_add.sv
// Redirect target adder: base+offset (wrapping), optional JALR bit-0 clear,
// and a flag when the resulting target is not instruction aligned.
module pc_target_add #(
  parameter int XLEN       = 32,
  parameter int ALIGN_BITS = 2
) (
  input  logic [XLEN-1:0] base_i,
  input  logic [XLEN-1:0] offset_i,
  input  logic            jalr_i,
  output logic [XLEN-1:0] target_o,
  output logic            misalign_o
);

  always_comb begin
    target_o = base_i + offset_i;
    if (jalr_i) target_o[0] = 1'b0;
  end

  // ALIGN_BITS must be at least 1.
  assign misalign_o = |target_o[ALIGN_BITS-1:0];

endmodule

// File: rtl/pc_gen.sv
// Registered PC generator: boot/run/halt FSM selecting step, redirect,
// trap entry or trap return, with EPC and bad-address capture.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter int              STEP         = 4,
  parameter int              ALIGN_BITS   = 2,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            redir_i,
  input  logic            jalr_i,
  input  logic [XLEN-1:0] base_i,
  input  logic [XLEN-1:0] offset_i,
  input  logic            trap_i,
  input  logic            mret_i,
  input  logic            halt_i,
  input  logic            resume_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus_o,
  output logic            pc_valid_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] badaddr_o,
  output logic [XLEN-1:0] epc_o
);

  localparam logic [XLEN-1:0] STEP_W = XLEN'(STEP);

  pc_state_e       state_q, state_d;
  pc_ctrl_t        ctrl;
  logic [XLEN-1:0] pc_q, pc_d, epc_q, epc_d, bad_q, bad_d;
  logic            mis_q, mis_d;
  logic [XLEN-1:0] tgt;
  logic            tgt_mis;

  pc_target_add #(.XLEN(XLEN), .ALIGN_BITS(ALIGN_BITS)) u_tadd (
    .base_i    (base_i),
    .offset_i  (offset_i),
    .jalr_i    (jalr_i),
    .target_o  (tgt),
    .misalign_o(tgt_mis)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_BOOT;
    else        state_q <= state_d;
  end

  // Trap outranks halt in RUN; in HALT a trap also wakes the core.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  if (!trap_i && halt_i) state_d = ST_HALT;
      ST_HALT: if (trap_i || resume_i) state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
  end

  always_comb begin
    ctrl = '{sel: SEL_HOLD, valid: 1'b0, save_epc: 1'b0, take_bad: 1'b0};
    case (state_q)
      ST_RUN: begin
        ctrl.valid = 1'b1;
        if (trap_i) begin
          ctrl.sel      = SEL_TRAP;
          ctrl.save_epc = 1'b1;
        end else if (halt_i) begin
          ctrl.sel = SEL_HOLD;
        end else if (mret_i) begin
          ctrl.sel = SEL_EPC;
        end else if (redir_i) begin
          // A misaligned target is handled as a trap entry on the same edge.
          if (tgt_mis) begin
            ctrl.sel      = SEL_TRAP;
            ctrl.save_epc = 1'b1;
            ctrl.take_bad = 1'b1;
          end else begin
            ctrl.sel = SEL_REDIR;
          end
        end else if (!stall_i) begin
          ctrl.sel = SEL_STEP;
        end
      end
      ST_HALT: begin
        if (trap_i) begin
          ctrl.sel      = SEL_TRAP;
          ctrl.save_epc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    case (ctrl.sel)
      SEL_STEP:  pc_d = pc_q + STEP_W;
      SEL_REDIR: pc_d = tgt;
      SEL_TRAP:  pc_d = TRAP_VECTOR;
      SEL_EPC:   pc_d = epc_q;
      default:   pc_d = pc_q;
    endcase
    epc_d = ctrl.save_epc ? pc_q : epc_q;
    bad_d = ctrl.take_bad ? tgt : bad_q;
    mis_d = ctrl.take_bad;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_VECTOR;
      epc_q <= '0;
      bad_q <= '0;
      mis_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
      bad_q <= bad_d;
      mis_q <= mis_d;
    end
  end

  assign pc_o       = pc_q;
  assign pc_plus_o  = pc_q + STEP_W;
  assign pc_valid_o = ctrl.valid;
  assign misalign_o = mis_q;
  assign badaddr_o  = bad_q;
  assign epc_o      = epc_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios followed by random
// traffic, all compared against a behavioural model of the PC rules.
module tb_pc_gen;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 0, redir_i = 0, jalr_i = 0, trap_i = 0, mret_i = 0;
  logic        halt_i = 0, resume_i = 0;
  logic [31:0] base_i = '0, offset_i = '0;
  logic [31:0] pc_o, pc_plus_o, badaddr_o, epc_o;
  logic        pc_valid_o, misalign_o;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit          m_boot, m_halt, m_mis;
  logic [31:0] m_pc, m_epc, m_bad;

  pc_gen dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .redir_i(redir_i),
    .jalr_i(jalr_i), .base_i(base_i), .offset_i(offset_i), .trap_i(trap_i),
    .mret_i(mret_i), .halt_i(halt_i), .resume_i(resume_i), .pc_o(pc_o),
    .pc_plus_o(pc_plus_o), .pc_valid_o(pc_valid_o), .misalign_o(misalign_o),
    .badaddr_o(badaddr_o), .epc_o(epc_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},    pc_o, m_pc);
    chk({tag, ".plus"},  pc_plus_o, m_pc + 32'd4);
    chk({tag, ".valid"}, {31'd0, pc_valid_o}, {31'd0, !m_boot && !m_halt});
    chk({tag, ".mis"},   {31'd0, misalign_o}, {31'd0, m_mis});
    chk({tag, ".bad"},   badaddr_o, m_bad);
    chk({tag, ".epc"},   epc_o, m_epc);
  endtask

  task automatic model_reset();
    m_boot = 1; m_halt = 0; m_mis = 0;
    m_pc = RV; m_epc = '0; m_bad = '0;
  endtask

  // One clock edge of the architectural rules, applied to the sampled inputs.
  task automatic model_edge();
    logic [31:0] t;
    bit mis_n;
    mis_n = 0;
    if (m_boot) begin
      m_boot = 0;
    end else if (m_halt) begin
      if (trap_i) begin m_halt = 0; m_epc = m_pc; m_pc = TV; end
      else if (resume_i) m_halt = 0;
    end else if (trap_i) begin
      m_epc = m_pc; m_pc = TV;
    end else if (halt_i) begin
      m_halt = 1;
    end else if (mret_i) begin
      m_pc = m_epc;
    end else if (redir_i) begin
      t = base_i + offset_i;
      if (jalr_i && t % 2 == 1) t = t - 1;
      if (t % 4 != 0) begin
        m_epc = m_pc; m_pc = TV; m_bad = t; mis_n = 1;
      end else m_pc = t;
    end else if (!stall_i) begin
      m_pc = m_pc + 32'd4;
    end
    m_mis = mis_n;
  endtask

  task automatic cyc(input string tag, input bit tr, input bit mr, input bit hl,
                     input bit rs, input bit st, input bit rd, input bit jr,
                     input logic [31:0] b, input logic [31:0] o);
    trap_i = tr; mret_i = mr; halt_i = hl; resume_i = rs;
    stall_i = st; redir_i = rd; jalr_i = jr; base_i = b; offset_i = o;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    cyc(tag, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic redir(input string tag, input logic [31:0] b, input logic [31:0] o);
    cyc(tag, 0, 0, 0, 0, 0, 1, 0, b, o);
  endtask

  initial begin
    // reset and free run
    model_reset();
    #12;
    chk("rst.pc", pc_o, RV);
    chk("rst.valid", {31'd0, pc_valid_o}, 32'd0);
    chk("rst.epc", epc_o, 32'd0);
    @(negedge clk); rst_n = 1;
    check_all("boot0");
    for (int i = 0; i < 4; i++) idle("run");
    chk("run.pc12", pc_o, 32'd12);

    // redirects
    redir("redir1", 32'h5555_5554, 32'h0000_0010);
    chk("redir1.const", pc_o, 32'h5555_5564);
    redir("redir_wrap", 32'hFFFF_FFF0, 32'h0000_0020);
    chk("redir_wrap.const", pc_o, 32'h0000_0010);
    cyc("jalr", 0, 0, 0, 0, 0, 1, 1, 32'h1001, 32'h0);
    chk("jalr.const", pc_o, 32'h1000);
    redir("misal", 32'h1002, 32'h0);
    chk("misal.pc", pc_o, 32'h100);
    chk("misal.bad", badaddr_o, 32'h1002);
    chk("misal.epc", epc_o, 32'h1000);
    chk("misal.pulse", {31'd0, misalign_o}, 32'd1);
    idle("misal_after");
    chk("misal.clear", {31'd0, misalign_o}, 32'd0);

    // stall vs redirect
    for (int i = 0; i < 3; i++) cyc("stall", 0, 0, 0, 0, 1, 0, 0, 32'h0, 32'h0);
    chk("stall.const", pc_o, 32'h104);
    cyc("stall_redir", 0, 0, 0, 0, 1, 1, 0, 32'h2000, 32'h0);
    chk("stall_redir.const", pc_o, 32'h2000);

    // trap / mret
    redir("to3c", 32'h3C, 32'h0);
    idle("to40");
    cyc("trap", 1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    chk("trap.epc", epc_o, 32'h40);
    cyc("mret", 0, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    chk("mret.pc", pc_o, 32'h40);
    cyc("trap_mret", 1, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    chk("trap_mret.pc", pc_o, 32'h100);

    // halt / resume
    redir("to4", 32'h4, 32'h0);
    idle("to8");
    cyc("halt", 0, 0, 1, 0, 0, 0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) idle("halted");
    chk("halt.pc", pc_o, 32'h8);
    chk("halt.valid", {31'd0, pc_valid_o}, 32'd0);
    cyc("resume", 0, 0, 0, 1, 0, 0, 0, 32'h0, 32'h0);
    idle("after_resume");
    chk("resume.pc", pc_o, 32'd12);

    // asynchronous reset mid-stream
    #2 rst_n = 0;
    #1;
    model_reset();
    chk("async.pc", pc_o, RV);
    chk("async.valid", {31'd0, pc_valid_o}, 32'd0);
    chk("async.epc", epc_o, 32'd0);
    chk("async.bad", badaddr_o, 32'd0);
    @(negedge clk); rst_n = 1;
    check_all("reboot");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] b, o;
      b = $urandom();
      o = $urandom();
      if ($urandom_range(0, 1) == 0) begin b = b & 32'hFFFF_FFFC; o = o & 32'hFFFF_FFFC; end
      cyc("rand",
          $urandom_range(0, 99) < 6,  $urandom_range(0, 99) < 8,
          $urandom_range(0, 99) < 5,  $urandom_range(0, 99) < 30,
          $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 30,
          $urandom_range(0, 99) < 30, b, o);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
